// File: rtl/sorted_unpacker.sv
// sorted_unpacker
//
// Consumes one packed, already-sorted array of DIM elements (WIDTH bits each)
// through a valid/ready handshake and replays it as a scalar element stream
// with index and last flag. The next array can be accepted on the last beat
// of the current one, so arrays stream with no bubble.
//
// Optional feature macro: SORT_CHECK_EN
//   Adds the order_err output, a sticky flag raised when an emitted element
//   is smaller (unsigned) than the element emitted just before it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   packed array present on in_data
//   in_ready   array can be accepted this cycle (combinational on out_ready)
//   in_data    packed array, element k at bits [k*WIDTH +: WIDTH]
//   out_valid  out_data/out_idx/out_last valid
//   out_ready  downstream accepts current element
//   out_data   current element
//   out_idx    index of current element
//   out_last   high on element DIM-1
//   order_err  sticky order violation flag (SORT_CHECK_EN only)
//
// state | meaning
// IDLE  | no array held; ready to capture
// SEND  | replaying shadow register, one element per accepted beat

module sorted_unpacker #(
  parameter  int DIM   = 10,
  parameter  int WIDTH = 8,
  localparam int IDXW  = $clog2(DIM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIM*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [IDXW-1:0]      out_idx,
  output logic                 out_last
`ifdef SORT_CHECK_EN
  ,
  output logic                 order_err
`endif
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIM - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [DIM*WIDTH-1:0] shadow_q, shadow_d;

  logic [WIDTH-1:0]     elem [DIM];
  logic                 in_hs;
  logic                 out_hs;

  // Unpacked view of the shadow register so the element mux is a plain
  // array select rather than a variable part-select.
  for (genvar k = 0; k < DIM; k++) begin : g_elem
    assign elem[k] = shadow_q[k*WIDTH +: WIDTH];
  end

  assign out_valid = (state_q == SEND);
  assign out_idx   = idx_q;
  assign out_data  = elem[idx_q];
  // Gated with SEND so an idle block never reports a last element.
  assign out_last  = (state_q == SEND) && (idx_q == LAST_IDX);

  // Ready on the last beat lets the next array enter on the same edge the
  // current one finishes.
  assign in_ready  = !rst && ((state_q == IDLE) || (out_last && out_ready));

  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    unique case (state_q)
      IDLE: begin
        if (in_hs) begin
          shadow_d = in_data;
          idx_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (out_hs) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (in_hs) begin
              shadow_d = in_data;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

`ifdef SORT_CHECK_EN
  logic             order_err_q, order_err_d;
  logic [IDXW-1:0]  prev_idx;
  logic             descending;

  assign prev_idx   = idx_q - IDXW'(1);
  // Only meaningful when idx_q > 0; element 0 has no predecessor.
  assign descending = (idx_q != '0) && (elem[idx_q] < elem[prev_idx]);

  always_comb begin
    order_err_d = order_err_q;
    if (out_hs && descending) begin
      order_err_d = 1'b1;
    end
  end

  assign order_err = order_err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
`ifdef SORT_CHECK_EN
      order_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
`ifdef SORT_CHECK_EN
      order_err_q <= order_err_d;
`endif
    end
  end

  a_idx_range: assert property (@(posedge clk) disable iff (rst)
    idx_q <= LAST_IDX);

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(out_data) && $stable(out_idx) && $stable(out_last)));

endmodule

// File: tb/tb_sorted_unpacker.sv
// Directed bench for sorted_unpacker at DIM=4, WIDTH=8. Inputs are driven
// and outputs sampled 1 time unit after each rising edge.

module tb_sorted_unpacker;

  localparam int DIM   = 4;
  localparam int WIDTH = 8;
  localparam int IDXW  = $clog2(DIM);

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [DIM*WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [IDXW-1:0]      out_idx;
  logic                 out_last;
`ifdef SORT_CHECK_EN
  logic                 order_err;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [DIM*WIDTH-1:0] ARR_A   = {8'h40, 8'h30, 8'h20, 8'h10};
  localparam logic [DIM*WIDTH-1:0] ARR_B   = {8'h04, 8'h03, 8'h02, 8'h01};
  localparam logic [DIM*WIDTH-1:0] ARR_BAD = {8'h40, 8'h05, 8'h20, 8'h10};
  localparam logic [DIM*WIDTH-1:0] JUNK    = {8'hEE, 8'hDD, 8'hCC, 8'hBB};

  sorted_unpacker #(.DIM(DIM), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef SORT_CHECK_EN
    ,
    .order_err (order_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the element stream for one beat; exp_rdy is the expected in_ready.
  task automatic chk_elem(input string tag, input logic [7:0] d, input int k, input logic exp_rdy);
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " data"},  32'(out_data),  32'(d));
    chk({tag, " idx"},   32'(out_idx),   32'(k));
    chk({tag, " last"},  32'(out_last),  32'(k == DIM - 1));
    chk({tag, " in_rdy"}, 32'(in_ready), 32'(exp_rdy));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"},  32'(out_valid), 32'd0);
    chk({tag, " in_rdy"}, 32'(in_ready),  32'd1);
  endtask

  task automatic capture(input logic [DIM*WIDTH-1:0] arr);
    in_data  = arr;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = JUNK;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();

    chk("rst in_ready",  32'(in_ready),  32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data",  32'(out_data),  32'd0);
    chk("rst out_idx",   32'(out_idx),   32'd0);
    chk("rst out_last",  32'(out_last),  32'd0);
`ifdef SORT_CHECK_EN
    chk("rst order_err", 32'(order_err), 32'd0);
`endif

    rst = 1'b0;
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'd1);

    // Single array, full throughput; in_data changed to junk after capture.
    out_ready = 1'b1;
    capture(ARR_A);
    chk_elem("single e0", 8'h10, 0, 1'b0); tick();
    chk_elem("single e1", 8'h20, 1, 1'b0); tick();
    chk_elem("single e2", 8'h30, 2, 1'b0); tick();
    chk_elem("single e3", 8'h40, 3, 1'b1); tick();
    chk_idle("single end");

    // Backpressure on element 1 for three cycles.
    capture(ARR_A);
    chk_elem("bp e0", 8'h10, 0, 1'b0); tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_elem("bp hold", 8'h20, 1, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk_elem("bp e1", 8'h20, 1, 1'b0); tick();
    chk_elem("bp e2", 8'h30, 2, 1'b0); tick();
    // Last element held: in_ready must stay low until out_ready returns.
    out_ready = 1'b0;
    #1;
    chk_elem("bp e3 held", 8'h40, 3, 1'b0);
    out_ready = 1'b1;
    #1;
    chk_elem("bp e3", 8'h40, 3, 1'b1); tick();
    chk_idle("bp end");

    // Back-to-back arrays: B offered during A's last beat.
    capture(ARR_A);
    chk_elem("b2b a0", 8'h10, 0, 1'b0); tick();
    chk_elem("b2b a1", 8'h20, 1, 1'b0); tick();
    chk_elem("b2b a2", 8'h30, 2, 1'b0); tick();
    in_data  = ARR_B;
    in_valid = 1'b1;
    #1;
    chk_elem("b2b a3", 8'h40, 3, 1'b1);
    tick();
    in_valid = 1'b0;
    in_data  = JUNK;
    chk_elem("b2b b0", 8'h01, 0, 1'b0); tick();
    chk_elem("b2b b1", 8'h02, 1, 1'b0); tick();
    chk_elem("b2b b2", 8'h03, 2, 1'b0); tick();
    chk_elem("b2b b3", 8'h04, 3, 1'b1); tick();
    chk_idle("b2b end");

    // Reset after element 1 has been accepted.
    capture(ARR_A);
    chk_elem("mid e0", 8'h10, 0, 1'b0); tick();
    chk_elem("mid e1", 8'h20, 1, 1'b0); tick();
    rst = 1'b1;
    tick();
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    chk("mid rst in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    chk("mid post in_ready", 32'(in_ready), 32'd1);
    capture(ARR_B);
    chk_elem("mid b0", 8'h01, 0, 1'b0); tick();
    chk_elem("mid b1", 8'h02, 1, 1'b0); tick();
    chk_elem("mid b2", 8'h03, 2, 1'b0); tick();
    chk_elem("mid b3", 8'h04, 3, 1'b1); tick();
    chk_idle("mid end");

`ifdef SORT_CHECK_EN
    chk("sorted order_err", 32'(order_err), 32'd0);
    capture(ARR_BAD);
    chk_elem("bad e0", 8'h10, 0, 1'b0); tick();
    chk("bad e1 err", 32'(order_err), 32'd0);
    chk_elem("bad e1", 8'h20, 1, 1'b0); tick();
    chk("bad e2 err", 32'(order_err), 32'd0);
    chk_elem("bad e2", 8'h05, 2, 1'b0); tick();
    chk("bad e3 err", 32'(order_err), 32'd1);
    chk_elem("bad e3", 8'h40, 3, 1'b1); tick();
    chk("bad idle err", 32'(order_err), 32'd1);
    capture(ARR_A);
    for (int k = 0; k < DIM; k++) tick();
    chk("bad sticky err", 32'(order_err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("bad cleared err", 32'(order_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
